game_timer: RTL

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_pkg.sv | 11 +
 rtl/game_timer_if.sv | 27 ++
 rtl/game_prescaler.sv | 34 +++
 rtl/game_timer.sv | 93 +++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared defaults and the count-direction type for the game timer slice.
package game_pkg;
  localparam int DEF_BASE_DIV = 5000000;
  localparam int DEF_SPEED_W  = 2;
  localparam int DEF_COUNT_W  = 10;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } count_dir_e;
endpackage

// File: rtl/game_timer_if.sv
// Control/status bundle between a game timer and whoever drives it.
interface game_timer_if #(
  parameter int SPEED_W = 2,
  parameter int COUNT_W = 10
);
  logic               enable;
  logic [SPEED_W-1:0] speed;
  logic               clear;
  logic               mode_down;
  logic [COUNT_W-1:0] load_value;
  logic               wrap_en;
  logic               write;
  logic [COUNT_W-1:0] count;
  logic               tick;
  logic               expired;
  logic               write_tick;

  modport master (
    output enable, speed, clear, mode_down, load_value, wrap_en, write,
    input  count, tick, expired, write_tick
  );

  modport slave (
    input  enable, speed, clear, mode_down, load_value, wrap_en, write,
    output count, tick, expired, write_tick
  );
endinterface

// File: rtl/game_prescaler.sv
// Clock divider for the game timer: raises tick_raw once every BASE_DIV >> speed
// enabled cycles; tick_raw is combinational so the count updates on the same edge.
module game_prescaler
  import game_pkg::*;
#(
  parameter int BASE_DIV = DEF_BASE_DIV,
  parameter int SPEED_W  = DEF_SPEED_W
) (
  input  logic               CLOCK50M,
  input  logic               RESET_N,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  input  logic               restart,
  output logic               tick_raw
);
  logic [31:0] presc;
  logic [31:0] term;

  assign term = (32'(BASE_DIV) >> speed) - 32'd1;

  // A speed change can leave presc above the new terminal; restart silently then.
  always_ff @(posedge CLOCK50M) begin
    if (!RESET_N) begin
      presc <= '0;
    end else if (restart) begin
      presc <= '0;
    end else if (enable) begin
      if (presc >= term) presc <= '0;
      else               presc <= presc + 32'd1;
    end
  end

  assign tick_raw = enable && !restart && (presc == term);
endmodule

// File: rtl/game_timer.sv
// Up/down game timer with wrap or saturate-and-expire at the terminal count.
// Optional GAME_TIMER_WRITE_SYNC_EN: defer write requests to the next tick (write_tick).
module game_timer
  import game_pkg::*;
#(
  parameter int BASE_DIV = DEF_BASE_DIV,
  parameter int SPEED_W  = DEF_SPEED_W,
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int LIMIT    = 2**COUNT_W - 1
) (
  input  logic    CLOCK50M,
  input  logic    RESET_N,
  game_timer_if.slave bus
);
  if ((BASE_DIV >> (2**SPEED_W - 1)) < 2) begin : g_div_check
    $error("game_timer: BASE_DIV too small for the fastest speed setting");
  end

  count_dir_e         mode_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_next;
  logic               tick_q;
  logic               expired_q;
  logic               tick_raw;
  logic               at_term;
  logic               do_tick;

  game_prescaler #(
    .BASE_DIV (BASE_DIV),
    .SPEED_W  (SPEED_W)
  ) u_prescaler (
    .CLOCK50M (CLOCK50M),
    .RESET_N  (RESET_N),
    .enable   (bus.enable && !expired_q),
    .speed    (bus.speed),
    .restart  (bus.clear),
    .tick_raw (tick_raw)
  );

  // A raw tick that lands on the terminal in saturate mode expires instead of counting.
  always_comb begin
    at_term    = (mode_q == DOWN) ? (count_q == '0) : (count_q == COUNT_W'(LIMIT));
    do_tick    = tick_raw && (bus.wrap_en || !at_term);
    count_next = count_q;
    if (mode_q == DOWN) count_next = at_term ? bus.load_value : count_q - COUNT_W'(1);
    else                count_next = at_term ? '0 : count_q + COUNT_W'(1);
  end

  always_ff @(posedge CLOCK50M) begin
    if (!RESET_N) begin
      count_q   <= '0;
      mode_q    <= UP;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (bus.clear) begin
      count_q   <= bus.mode_down ? bus.load_value : '0;
      mode_q    <= bus.mode_down ? DOWN : UP;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      tick_q <= do_tick;
      if (do_tick) count_q <= count_next;
      if (tick_raw && !do_tick) expired_q <= 1'b1;
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.expired = expired_q;

`ifdef GAME_TIMER_WRITE_SYNC_EN
  logic pending_q;
  logic write_tick_q;

  // A write seen on a tick edge belongs to the following tick.
  always_ff @(posedge CLOCK50M) begin
    if (!RESET_N || bus.clear) begin
      pending_q    <= 1'b0;
      write_tick_q <= 1'b0;
    end else begin
      write_tick_q <= do_tick && pending_q;
      if (do_tick) pending_q <= bus.write;
      else         pending_q <= pending_q || bus.write;
    end
  end

  assign bus.write_tick = write_tick_q;
`else
  logic unused_write;
  assign unused_write   = bus.write;
  assign bus.write_tick = 1'b0;
`endif
endmodule
